ssio_sdr_out_burst: RTL and testbench

Source-synchronous SDR transmitter with forwarded clock, burst framing and input flow control. Accepts words on a valid/ready stream, holds them in a 2-entry skid buffer, and drives IOB-packed data and enable registers plus an ODDR-forwarded clock. The forwarded clock runs for a programmable lead-in before each burst and a trail-out after it. Sits between MAC-side TX logic and PHY/FPGA pins, as the next generation of the plain SDR output stage.

---
 rtl/ssio_sdr_out_burst.sv | 215 +++++++++++++++++++++
 tb/tb_ssio_sdr_out_burst.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssio_sdr_out_burst.sv
// ssio_sdr_out_burst: SDR source-synchronous transmitter with burst framing.
// Skid-buffered stream in, IOB data/enable out, ODDR-style forwarded clock.
//
// Ports:
//   clk         single clock, all state on its rising edge
//   rst_n       asynchronous active-low reset
//   s_data      word to send (WIDTH)
//   s_valid     s_data valid
//   s_ready     registered; transfer on s_valid && s_ready at a rising edge
//   output_clk  forwarded clock, high during the low phase of clk
//   output_q    IOB data register (IDLE_VALUE between words)
//   output_en   IOB register, 1 while output_q carries a word
//   busy        FSM not idle or skid buffer non-empty
//
// Build option: define SSIO_SDR_OUT_BURST_CLK_GATE_EN to gate output_clk
// to the lead-in/data/trail-out window; otherwise it is free-running.

module ssio_sdr_out_burst #(
  parameter string TARGET = "GENERIC",
  parameter string IODDR_STYLE = "IODDR2",
  parameter int WIDTH = 8,
  parameter int LEAD_CYCLES = 2,
  parameter int TRAIL_CYCLES = 2,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             output_clk,
  output logic [WIDTH-1:0] output_q,
  output logic             output_en,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LEAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_TRAIL  = 2'd3;

  localparam logic [3:0] LEAD_INIT =
    (LEAD_CYCLES > 0) ? 4'(LEAD_CYCLES - 1) : 4'd0;
  localparam logic [3:0] TRAIL_INIT =
    (TRAIL_CYCLES > 0) ? 4'(TRAIL_CYCLES - 1) : 4'd0;

  // Hardware targets and the Spartan-6 ODDR2 pair get a registered
  // falling-edge half; the plain SIM model samples d2 directly.
  localparam bit D2_REG =
    (TARGET != "SIM") || (IODDR_STYLE == "IODDR2");

  // ---------------- skid buffer ----------------
  logic [WIDTH-1:0] buf_mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_d;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign push = s_valid && ready_q;
  assign head = buf_mem[rd_ptr];
  assign s_ready = ready_q;

  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + 2'd1;
      2'b01:   count_d = count - 2'd1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_d;
      ready_q <= (count_d < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= s_data;
  end

  // ---------------- burst FSM ----------------
  logic [1:0] state;
  logic [1:0] state_d;
  logic [3:0] cnt;
  logic [3:0] cnt_d;
  logic       gate;
  logic       gate_d;
  logic       has_word;

  assign has_word = (count != 2'd0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gate_d  = gate;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (has_word) begin
          gate_d = 1'b1;
          if (LEAD_CYCLES == 0) begin
            state_d = S_ACTIVE;
            pop     = 1'b1;
          end else begin
            state_d = S_LEAD;
            cnt_d   = LEAD_INIT;
          end
        end
      end
      S_LEAD: begin
        // The buffer cannot drain while in lead-in, so a word is present.
        if (cnt == 4'd0) begin
          state_d = S_ACTIVE;
          pop     = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_ACTIVE: begin
        if (has_word) begin
          pop = 1'b1;
        end else if (TRAIL_CYCLES == 0) begin
          state_d = S_IDLE;
          gate_d  = 1'b0;
        end else begin
          state_d = S_TRAIL;
          cnt_d   = TRAIL_INIT;
        end
      end
      S_TRAIL: begin
        // A new word resumes the burst without another lead-in,
        // even on the last trail-out cycle.
        if (has_word) begin
          state_d = S_ACTIVE;
          pop     = 1'b1;
        end else if (cnt == 4'd0) begin
          state_d = S_IDLE;
          gate_d  = 1'b0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = 1'b0;
      end
    endcase
  end

  logic [WIDTH-1:0] q_reg;
  logic             en_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      gate   <= 1'b0;
      q_reg  <= IDLE_VALUE;
      en_reg <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      gate   <= gate_d;
      q_reg  <= pop ? head : IDLE_VALUE;
      en_reg <= pop;
    end
  end

  assign output_q  = q_reg;
  assign output_en = en_reg;
  assign busy = (state != S_IDLE) || has_word || gate;

  // ---------------- forwarded clock ----------------
  // d1 = 0 drives the high phase of clk, d2 the low phase, so a
  // rising edge of output_clk lands mid-way through each data cycle.
  logic d2;

`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
  assign d2 = gate;
`else
  assign d2 = 1'b1;
`endif

  generate
    if (D2_REG) begin : g_oddr_reg
`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
      localparam logic D2_RST = 1'b0;
`else
      localparam logic D2_RST = 1'b1;
`endif
      logic d2_q;
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) d2_q <= D2_RST;
        else d2_q <= d2;
      end
      assign output_clk = ~clk & d2_q;
    end else begin : g_oddr_comb
      assign output_clk = ~clk & d2;
    end
  endgenerate

endmodule

// File: tb/tb_ssio_sdr_out_burst.sv
// tb_ssio_sdr_out_burst: random + directed bench for ssio_sdr_out_burst.
// Two instances (LEAD/TRAIL 2/2 and 0/0) against a word-schedule model.
`timescale 1ns/1ps
module tb_ssio_sdr_out_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       rdy  [2];
  logic       oclk [2];
  logic [7:0] q    [2];
  logic       en   [2];
  logic       bsy  [2];

  always #5 clk = ~clk;

  ssio_sdr_out_burst #(
    .TARGET("GENERIC"), .IODDR_STYLE("IODDR2"), .WIDTH(8),
    .LEAD_CYCLES(2), .TRAIL_CYCLES(2), .IDLE_VALUE(8'h00)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[0]), .output_clk(oclk[0]), .output_q(q[0]),
    .output_en(en[0]), .busy(bsy[0])
  );

  ssio_sdr_out_burst #(
    .TARGET("SIM"), .IODDR_STYLE("IODDR"), .WIDTH(8),
    .LEAD_CYCLES(0), .TRAIL_CYCLES(0), .IDLE_VALUE(8'h3C)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(rdy[1]), .output_clk(oclk[1]), .output_q(q[1]),
    .output_en(en[1]), .busy(bsy[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ld(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic int trl(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic logic [7:0] idle_v(input int d);
    return (d == 0) ? 8'h00 : 8'h3C;
  endfunction
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Word schedule: accept edge, emit edge, first gated edge, data.
  localparam int MAXW = 4096;
  int         w_t [2][MAXW];
  int         w_e [2][MAXW];
  int         w_s [2][MAXW];
  logic [7:0] w_d [2][MAXW];
  int nw [2];
  int lo [2];
  int prev_e [2];
  bit m_ready [2];
  bit acc [2];
  int first_en [2];
  int last_en [2];
  int en_cnt [2];
  int busy_cnt [2];
  int pulse_cnt [2];
  int cyc_n = 0;

  task automatic model_reset(input int d);
    lo[d] = nw[d];
    prev_e[d] = -1000;
    m_ready[d] = 1'b0;
  endtask

  function automatic int pend(input int d, input int n);
    int c;
    c = 0;
    for (int i = lo[d]; i < nw[d]; i++)
      if (w_t[d][i] <= n && w_e[d][i] > n) c++;
    return c;
  endfunction

  function automatic bit gate_exp(input int d, input int n);
    bit g;
    g = 1'b0;
    for (int i = lo[d]; i < nw[d]; i++)
      if (w_s[d][i] <= n && n <= w_e[d][i] + trl(d)) g = 1'b1;
    return g;
  endfunction

  task automatic step(input int d, input int n);
    int cand;
    int e;
    int s;
    acc[d] = 1'b0;
    if (!rst_n) begin
      m_ready[d] = 1'b0;
      return;
    end
    while (lo[d] < nw[d] && w_e[d][lo[d]] + trl(d) < n) lo[d]++;
    if (m_ready[d] && s_valid && nw[d] < MAXW) begin
      cand = imax(n + 1, prev_e[d] + 1);
      if (cand <= prev_e[d] + 1 + trl(d)) begin
        e = cand;
        s = cand;
      end else begin
        s = imax(n + 1, prev_e[d] + 2 + trl(d));
        e = s + ld(d);
      end
      w_t[d][nw[d]] = n;
      w_e[d][nw[d]] = e;
      w_s[d][nw[d]] = s;
      w_d[d][nw[d]] = s_data;
      nw[d]++;
      prev_e[d] = e;
      acc[d] = 1'b1;
    end
    m_ready[d] = (pend(d, n) < 2);
  endtask

  task automatic check_outs(input int d, input int n, input bit stats);
    bit xe;
    logic [7:0] xq;
    bit g;
    bit xc;
    int p;
    xe = 1'b0;
    xq = idle_v(d);
    for (int i = lo[d]; i < nw[d]; i++)
      if (w_e[d][i] == n) begin
        xe = 1'b1;
        xq = w_d[d][i];
      end
    g = gate_exp(d, n);
    p = pend(d, n);
`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
    xc = clk ? 1'b0 : g;
`else
    xc = ~clk;
`endif
    chk($sformatf("u%0d.en@%0d", d, n), en[d], xe);
    chk($sformatf("u%0d.q@%0d", d, n), q[d], xq);
    chk($sformatf("u%0d.ready@%0d", d, n), rdy[d], m_ready[d]);
    chk($sformatf("u%0d.busy@%0d", d, n), bsy[d], g || (p > 0));
    chk($sformatf("u%0d.oclk@%0d", d, n), oclk[d], xc);
    if (stats) begin
      if (en[d]) begin
        if (first_en[d] < 0) first_en[d] = n;
        last_en[d] = n;
        en_cnt[d]++;
      end
      if (bsy[d]) busy_cnt[d]++;
    end else if (oclk[d]) begin
      pulse_cnt[d]++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < 2; d++) step(d, cyc_n);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d, cyc_n, 1'b1);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d, cyc_n, 1'b0);
    cyc_n++;
  endtask

  task automatic clr_stats();
    for (int d = 0; d < 2; d++) begin
      first_en[d] = -1;
      last_en[d] = -1;
      en_cnt[d] = 0;
      busy_cnt[d] = 0;
      pulse_cnt[d] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta;
    int t2;
    int k;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    for (int d = 0; d < 2; d++) begin
      nw[d] = 0;
      model_reset(d);
    end
    clr_stats();
    repeat (3) cyc();
    chk("rst_ready", rdy[0], 1'b0);
    chk("rst_q1", q[1], 8'h3C);
    rst_n = 1'b1;
    cyc();
    chk("ready_up", rdy[0], 1'b1);
    repeat (4) cyc();

    // single word 0xA5
    clr_stats();
    s_valid = 1'b1;
    s_data = 8'hA5;
    ta = cyc_n;
    cyc();
    s_valid = 1'b0;
    repeat (12) cyc();
    chk("a_lat0", first_en[0] - ta, 3);
    chk("a_lat1", first_en[1] - ta, 1);
    chk("a_cnt0", en_cnt[0], 1);
    chk("a_busy0", busy_cnt[0], 6);
    chk("a_busy1", busy_cnt[1], 2);
`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
    chk("a_gate0", pulse_cnt[0], 5);
    chk("a_gate1", pulse_cnt[1], 1);
`endif

    // 16-word back-to-back burst on u0
    clr_stats();
    k = 0;
    s_valid = 1'b1;
    s_data = 8'(k);
    for (int g = 0; g < 100 && k < 16; g++) begin
      cyc();
      if (acc[0]) begin
        k++;
        s_data = 8'(k);
      end
    end
    s_valid = 1'b0;
    chk("b_acc", k, 16);
    repeat (25) cyc();
    chk("b_cnt0", en_cnt[0], 16);
    chk("b_span0", last_en[0] - first_en[0], 15);
    chk("b_busy0", busy_cnt[0], 21);
`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
    chk("b_gate0", pulse_cnt[0], 20);
`endif

    // second word lands in u0's trail-out
    clr_stats();
    s_valid = 1'b1;
    s_data = 8'h11;
    ta = cyc_n;
    cyc();
    s_valid = 1'b0;
    repeat (3) cyc();
    s_valid = 1'b1;
    s_data = 8'h22;
    t2 = cyc_n;
    cyc();
    s_valid = 1'b0;
    repeat (12) cyc();
    chk("c_lat0", last_en[0] - t2, 1);
    chk("c_first0", first_en[0] - ta, 3);
    chk("c_busy0", busy_cnt[0], 8);
`ifdef SSIO_SDR_OUT_BURST_CLK_GATE_EN
    chk("c_gate0", pulse_cnt[0], 7);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 10)) cyc();
      end
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = 8'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    repeat (20) cyc();

    // reset with two words buffered in u0's lead-in
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'h70 + 8'(i);
      cyc();
    end
    chk("e_pend0", bsy[0], 1'b1);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) model_reset(d);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d, cyc_n, 1'b0);
    chk("e_busy0", bsy[0], 1'b0);
    s_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    clr_stats();
    repeat (20) cyc();
    chk("e_stale0", en_cnt[0], 0);
    chk("e_stale1", en_cnt[1], 0);

    clr_stats();
    s_valid = 1'b1;
    s_data = 8'h5A;
    ta = cyc_n;
    cyc();
    s_valid = 1'b0;
    repeat (12) cyc();
    chk("f_lat0", first_en[0] - ta, 3);
    chk("f_lat1", first_en[1] - ta, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
